uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_MHZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 3_000_000, meaning the line rate of the downstream transmitter.
REQ-003 The block SHALL have parameter NUM_DATA_BITS, default 8, range 5-9, meaning the transmitter byte width.
REQ-004 The block SHALL have parameter PARITY_ON, default 1, range 0-1, meaning the transmitter frame includes a parity bit.
REQ-005 The block SHALL have parameter NUM_STOP_BITS, default 1, range 1-2, meaning the transmitter frame's stop-bit count.
REQ-006 The block SHALL have parameter NUM_REQ, default 3, range 2-8, meaning the number of requesters.
REQ-007 The block SHALL have parameter BYTES_PER_MSG, default 4, range 1-8, meaning the bytes per message.
REQ-008 The block SHALL have parameter HEADER_EN, default 1, meaning a header byte precedes each message.
REQ-009 The block SHALL have port i_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-010 The block SHALL have port i_rst, input, width 1: reset, synchronous and active-high.
REQ-011 The block SHALL have port i_req_valid, input, width NUM_REQ: per-requester message valid.
REQ-012 The block SHALL have port i_req_data, input, width NUM_REQ*BYTES_PER_MSG*NUM_DATA_BITS: flattened messages; requester k occupies slice k; byte 0 is the least significant.
REQ-013 The block SHALL have port o_req_ready, output, width NUM_REQ: one-hot accept.
REQ-014 The block SHALL have port o_tx_byte_valid, output, width 1: one-cycle byte strobe to the transmitter.
REQ-015 The block SHALL have port o_tx_byte, output, width NUM_DATA_BITS: the byte sent to the transmitter.
REQ-016 The block SHALL have port o_grant_id, output, width max(1,clog2(NUM_REQ)): the requester currently being serviced.
REQ-017 The block SHALL have port o_busy, output, width 1: high whenever state is not IDLE.

Function
REQ-018 Derived constants SHALL be computed at elaboration as: BAUD_CYC = int'(real CLK_FREQ_MHZ / real BAUD_RATE), rounded to nearest (33 at defaults).
REQ-019 FRAME_BITS SHALL equal 1 + NUM_DATA_BITS + PARITY_ON + NUM_STOP_BITS.
REQ-020 GAP_CYC SHALL equal BAUD_CYC*FRAME_BITS + 2, giving 365 at defaults; the 2 cycles are guard time for the transmitter's return to idle.
REQ-021 MSG_LEN SHALL equal BYTES_PER_MSG + HEADER_EN.
REQ-022 The state machine SHALL have the states IDLE, SEND and WAIT.
REQ-023 In IDLE, o_req_ready SHALL be combinational and one-hot on the round-robin winner among asserted i_req_valid bits; it SHALL be all-zero in every other state and when no valid is asserted.
REQ-024 Round-robin search SHALL start at (last_grant+1) mod NUM_REQ and ascend with wrap.
REQ-025 last_grant SHALL update to the winner on each accept.
REQ-026 A handshake SHALL occur in the cycle where i_req_valid[k] and o_req_ready[k] are both high; on that edge the block SHALL latch slice k, latch o_grant_id=k, clear the byte index and go to SEND.
REQ-027 Requesters SHALL hold valid and data stable until accepted; a valid deasserted before acceptance SHALL be ignored without error.
REQ-028 In SEND, the block SHALL register o_tx_byte_valid=1 for exactly one cycle, then go to WAIT.
REQ-029 The byte sent at index 0 SHALL be the header when HEADER_EN=1, i.e. {4'hA, grant id zero-extended to 4 bits}, truncated to the low NUM_DATA_BITS.
REQ-030 All subsequent bytes SHALL be message bytes 0..BYTES_PER_MSG-1, LSB first.
REQ-031 o_tx_byte SHALL hold its value until the next SEND.
REQ-032 The latency from the handshake edge to the first o_tx_byte_valid SHALL be 1 cycle.
REQ-033 In WAIT, a counter SHALL run from 0 to GAP_CYC-2; the o_tx_byte_valid pulses of one message are therefore exactly GAP_CYC cycles apart.
REQ-034 On terminal count in WAIT, the block SHALL go to SEND if the byte index is below MSG_LEN-1, otherwise to IDLE.
REQ-035 The counter SHALL reset to 0 on every WAIT entry.
REQ-036 A message SHALL never be preempted; a new i_req_valid during SEND or WAIT SHALL wait.
REQ-037 Consecutive messages SHALL be separated by at least GAP_CYC+1 cycles, because IDLE consumes one cycle.
REQ-038 Unreachable state encodings SHALL return to IDLE with outputs at their reset values.

Reset
REQ-039 While i_rst is high at a clock edge, the block SHALL enter IDLE.
REQ-040 Reset SHALL set o_tx_byte_valid=0, o_tx_byte=0, o_grant_id=0, o_busy=0, last_grant=NUM_REQ-1 (so requester 0 wins first), and clear the counter and index.
REQ-041 A reset asserted mid-message SHALL abandon the message with no further strobes and no error.

Verification
REQ-042 Defaults; single request: req0 valid with data 0x44332211 -> ready[0] high 1 cycle; strobes carry A0,11,22,33,44 and are 365 cycles apart; o_busy is 0 one cycle after the last WAIT.
REQ-043 All three requesters valid continuously from reset -> grant order 0,1,2,0 and each message has 5 bytes.
REQ-044 req2 is served, then req0 and req2 are both valid -> req0 wins because the search starts at 0.
REQ-045 HEADER_EN=0, BYTES_PER_MSG=1, PARITY_ON=0, NUM_STOP_BITS=2 -> GAP_CYC=365 and one strobe per message.
REQ-046 i_rst is pulsed during the WAIT after byte 2 -> no further strobes; the next request gets a header with grant id 0.
REQ-047 req1 valid during WAIT of req0's message -> ready[1] stays low until IDLE, and req1 is accepted in the IDLE cycle.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin message scheduler for a UART transmitter. It accepts one message at a time and
// emits its bytes (an optional header first) as single-cycle strobes spaced one full frame apart.
module uart_tx_scheduler #(
   parameter int CLK_FREQ_MHZ  = 100_000_000,
   parameter int BAUD_RATE     = 3_000_000,
   parameter int NUM_DATA_BITS = 8,
   parameter int PARITY_ON     = 1,
   parameter int NUM_STOP_BITS = 1,
   parameter int NUM_REQ       = 3,
   parameter int BYTES_PER_MSG = 4,
   parameter int HEADER_EN     = 1
) (
   input  logic                                            i_clk,
   input  logic                                            i_rst,
   input  logic [NUM_REQ-1:0]                              i_req_valid,
   input  logic [NUM_REQ*BYTES_PER_MSG*NUM_DATA_BITS-1:0]  i_req_data,
   output logic [NUM_REQ-1:0]                              o_req_ready,
   output logic                                            o_tx_byte_valid,
   output logic [NUM_DATA_BITS-1:0]                        o_tx_byte,
   output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_grant_id,
   output logic                                            o_busy
);

   localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int MW         = BYTES_PER_MSG * NUM_DATA_BITS;
   localparam int BAUD_CYC   = int'(real'(CLK_FREQ_MHZ) / real'(BAUD_RATE));
   localparam int FRAME_BITS = 1 + NUM_DATA_BITS + PARITY_ON + NUM_STOP_BITS;
   localparam int GAP_CYC    = BAUD_CYC * FRAME_BITS + 2;
   localparam int MSG_LEN    = BYTES_PER_MSG + HEADER_EN;
   localparam int CW         = $clog2(GAP_CYC);
   localparam int IW         = $clog2(MSG_LEN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t                   state, state_nxt;
   logic [GW-1:0]            last_grant;
   logic [GW-1:0]            winner;
   logic                     win_vld;
   logic                     wait_done;
   logic [CW-1:0]            cnt;
   logic [IW-1:0]            idx;
   logic [MW-1:0]            msg_q;
   logic [NUM_DATA_BITS-1:0] byte_sel;

   // Search starts just after the previous winner and wraps; MSB of the result flags a hit.
   function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                           input logic [GW-1:0]      last);
      logic [GW:0] res;
      int          j;
      res = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         j = int'(last) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!res[GW] && vld[j]) res = {1'b1, GW'(j)};
      end
      return res;
   endfunction

   function automatic logic [NUM_DATA_BITS-1:0] header_byte(input logic [GW-1:0] gid);
      logic [7:0] h;
      h = {4'hA, 4'(gid)};
      return NUM_DATA_BITS'(h);
   endfunction

   function automatic logic [NUM_DATA_BITS-1:0] msg_byte(input logic [MW-1:0] msg,
                                                         input logic [IW-1:0] i);
      int b;
      b = int'(i) - HEADER_EN;
      if (b < 0) b = 0;
      return msg[b*NUM_DATA_BITS +: NUM_DATA_BITS];
   endfunction

   always_comb begin
      {win_vld, winner} = rr_pick(i_req_valid, last_grant);
      o_req_ready       = '0;
      state_nxt         = state;
      wait_done         = (cnt == CW'(GAP_CYC - 2));
      byte_sel          = ((HEADER_EN != 0) && (idx == '0)) ? header_byte(o_grant_id)
                                                           : msg_byte(msg_q, idx);
      case (state)
         IDLE: begin
            if (win_vld) begin
               o_req_ready[winner] = 1'b1;
               state_nxt           = SEND;
            end
         end
         SEND: state_nxt = WAIT;
         WAIT: begin
            if (wait_done) state_nxt = (int'(idx) < MSG_LEN - 1) ? SEND : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= IDLE;
         o_tx_byte_valid <= 1'b0;
         o_tx_byte       <= '0;
         o_grant_id      <= '0;
         last_grant      <= GW'(NUM_REQ - 1);
         cnt             <= '0;
         idx             <= '0;
      end else begin
         state           <= state_nxt;
         o_tx_byte_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  o_grant_id <= winner;
                  last_grant <= winner;
                  idx        <= '0;
               end
            end
            SEND: begin
               o_tx_byte_valid <= 1'b1;
               o_tx_byte       <= byte_sel;
               cnt             <= '0;
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (wait_done) idx <= idx + 1'b1;
            end
            default: begin
               o_tx_byte  <= '0;
               o_grant_id <= '0;
               last_grant <= GW'(NUM_REQ - 1);
               cnt        <= '0;
               idx        <= '0;
            end
         endcase
      end
   end

   // Message payload is pure data: captured on accept, never reset.
   always_ff @(posedge i_clk) begin
      if (state == IDLE && win_vld) msg_q <= i_req_data[winner*MW +: MW];
   end

   assign o_busy = (state == SEND) || (state == WAIT);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: default build plus a headerless one-byte build.
module tb_uart_tx_scheduler;
   localparam int NR  = 3;
   localparam int GAP = 365;

   logic        clk = 1'b0;
   logic        rst, rst_b;
   logic [2:0]  vld, vld_b;
   logic [95:0] data;
   logic [23:0] data_b;
   logic [2:0]  rdy, rdy_b;
   logic        txv, txv_b, busy, busy_b;
   logic [7:0]  txb, txb_b;
   logic [1:0]  gid, gid_b;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int         s_cyc[$];
   logic [7:0] s_byte[$];
   logic [1:0] s_gid[$];
   int         b_cyc[$];
   logic [7:0] b_byte[$];
   logic [1:0] b_gid[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_scheduler dut (
      .i_clk(clk), .i_rst(rst), .i_req_valid(vld), .i_req_data(data),
      .o_req_ready(rdy), .o_tx_byte_valid(txv), .o_tx_byte(txb),
      .o_grant_id(gid), .o_busy(busy)
   );

   uart_tx_scheduler #(
      .HEADER_EN(0), .BYTES_PER_MSG(1), .PARITY_ON(0), .NUM_STOP_BITS(2)
   ) dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_req_valid(vld_b), .i_req_data(data_b),
      .o_req_ready(rdy_b), .o_tx_byte_valid(txv_b), .o_tx_byte(txb_b),
      .o_grant_id(gid_b), .o_busy(busy_b)
   );

   always @(negedge clk) begin
      if (txv) begin
         s_cyc.push_back(cyc); s_byte.push_back(txb); s_gid.push_back(gid);
      end
      if (txv_b) begin
         b_cyc.push_back(cyc); b_byte.push_back(txb_b); b_gid.push_back(gid_b);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_n(input int n, input int budget);
      int k = 0;
      while (s_cyc.size() < n && k < budget) begin tick(1); k++; end
      chk("strobe_cnt", s_cyc.size(), n);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin tick(1); k++; end
      chk("idle_tmo", busy, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1; vld = '0;
      tick(3);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d limit=200000", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] t1_exp [5];
      logic [1:0] t2_gid [4];
      logic [7:0] b_exp  [3];
      logic [1:0] b_gexp [3];
      int base, h, last, viol, k;
      t1_exp = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h44};
      t2_gid = '{2'd0, 2'd1, 2'd2, 2'd0};
      b_exp  = '{8'h5A, 8'hC3, 8'h5A};
      b_gexp = '{2'd0, 2'd1, 2'd0};
      rst = 1'b1; rst_b = 1'b1; vld = '0; vld_b = '0; data = '0; data_b = '0;
      tick(3);
      chk("rst_txv", txv, 0);
      chk("rst_txb", txb, 0);
      chk("rst_gid", gid, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick(1);
      chk("idle_rdy_none", rdy, 0);

      // single request
      data[31:0] = 32'h44332211;
      vld = 3'b001;
      #1 chk("t1_rdy", rdy, 3'b001);
      h = cyc; base = s_cyc.size();
      tick(1);
      vld = '0;
      #1 chk("t1_rdy_off", rdy, 0);
      chk("t1_busy", busy, 1);
      wait_n(base + 5, 5 * GAP + 20);
      if (s_cyc.size() >= base + 5) begin
         chk("t1_lat", s_cyc[base] - h, 2);
         for (int i = 0; i < 5; i++) chk($sformatf("t1_byte%0d", i), s_byte[base+i], t1_exp[i]);
         for (int i = 1; i < 5; i++) chk($sformatf("t1_gap%0d", i), s_cyc[base+i] - s_cyc[base+i-1], GAP);
         tick(10);
         chk("t1_hold", txb, 8'h44);
         last = s_cyc[base+4];
         while (cyc < last + GAP - 2) tick(1);
         chk("t1_busy_last", busy, 1);
         tick(1);
         chk("t1_busy_end", busy, 0);
      end

      // all three requesters valid from reset
      data = {32'hCCBBAA99, 32'h88776655, 32'h44332211};
      base = s_cyc.size();
      rst = 1'b1; vld = 3'b111;
      tick(3);
      rst = 1'b0;
      wait_n(base + 20, 20 * (GAP + 1) + 50);
      vld = '0;
      if (s_cyc.size() >= base + 20) begin
         for (int m = 0; m < 4; m++) begin
            chk($sformatf("t2_hdr%0d", m), s_byte[base+5*m], {4'hA, 2'b00, t2_gid[m]});
            chk($sformatf("t2_gid%0d", m), s_gid[base+5*m], t2_gid[m]);
         end
         chk("t2_req1_b0", s_byte[base+6], 8'h55);
         chk("t2_req2_b3", s_byte[base+14], 8'hCC);
         chk("t2_sep01", s_cyc[base+5] - s_cyc[base+4], GAP + 1);
         chk("t2_sep12", s_cyc[base+10] - s_cyc[base+9], GAP + 1);
      end
      wait_idle(6 * GAP);

      // req2 served, then req0 and req2 contend
      do_reset();
      vld = 3'b100;
      #1 chk("t3_rdy2", rdy, 3'b100);
      base = s_cyc.size();
      tick(1);
      vld = 3'b101;
      wait_idle(6 * GAP);
      chk("t3_rdy0", rdy, 3'b001);
      tick(1);
      vld = '0;
      chk("t3_gid", gid, 0);
      wait_n(base + 6, 2 * GAP);
      if (s_cyc.size() >= base + 6) chk("t3_hdr", s_byte[base+5], 8'hA0);
      wait_idle(6 * GAP);

      // req1 arrives mid-message and must wait for IDLE
      do_reset();
      vld = 3'b001;
      tick(1);
      vld = 3'b011;
      viol = 0; k = 0;
      while (busy && k < 6 * GAP) begin
         if (rdy != 3'b000) viol++;
         tick(1); k++;
      end
      chk("t4_rdy_hold", viol, 0);
      chk("t4_rdy1", rdy, 3'b010);
      tick(1);
      vld = '0;
      chk("t4_gid", gid, 1);
      chk("t4_busy", busy, 1);
      wait_idle(6 * GAP);

      // reset in the WAIT after the third strobe
      do_reset();
      base = s_cyc.size();
      vld = 3'b001;
      tick(1);
      vld = '0;
      wait_n(base + 3, 3 * GAP + 20);
      tick(100);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_txv", txv, 0);
      chk("t5_txb", txb, 0);
      chk("t5_gid", gid, 0);
      tick(2 * GAP);
      chk("t5_quiet", s_cyc.size(), base + 3);
      vld = 3'b011;
      #1 chk("t5_rdy", rdy, 3'b001);
      tick(1);
      vld = '0;
      wait_n(base + 4, 50);
      if (s_cyc.size() >= base + 4) begin
         chk("t5_hdr", s_byte[base+3], 8'hA0);
         chk("t5_hdr_gid", s_gid[base+3], 0);
      end
      wait_idle(6 * GAP);

      // headerless, one byte per message, no parity, two stop bits
      data_b = {8'h00, 8'hC3, 8'h5A};
      rst_b = 1'b0;
      vld_b = 3'b011;
      k = 0;
      while (b_cyc.size() < 3 && k < 3 * (GAP + 1) + 20) begin tick(1); k++; end
      vld_b = '0;
      chk("b_cnt", b_cyc.size(), 3);
      if (b_cyc.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("b_byte%0d", i), b_byte[i], b_exp[i]);
            chk($sformatf("b_gid%0d", i), b_gid[i], b_gexp[i]);
         end
         for (int i = 1; i < 3; i++) chk($sformatf("b_gap%0d", i), b_cyc[i] - b_cyc[i-1], GAP + 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
